uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the USART receiver.
- Captures each received byte and its parity flag when the receiver raises Data_Ready.
- Acknowledges the receiver with a one-cycle CLR_Rec pulse, which frees it for the next frame.
- Stores up to DEPTH words for a slower consumer (CPU/bus logic) that pops them with a read strobe.

Parameters:
- DATA_W, 8, width of received data word.
- ADDR_W, 4, FIFO address width; DEPTH = 2**ADDR_W = 16 entries.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- CLR  in  1  reset, synchronous, active-high.
- Data_Rx  in  DATA_W  byte from receiver; valid while Data_Ready=1.
- Data_Ready  in  1  receiver level flag; held high until CLR_Rec.
- parity_err  in  1  receiver parity flag for the current byte.
- CLR_Rec  out  1  one-cycle ack to receiver; clears its Data_Ready.
- Rd_En  in  1  pop request from consumer.
- Rd_Data  out  DATA_W  popped byte.
- Rd_Perr  out  1  parity flag stored with the popped byte.
- Rd_Valid  out  1  one-cycle strobe; Rd_Data/Rd_Perr are new this cycle.
- Empty  out  1  FIFO holds 0 words.
- Full  out  1  FIFO holds DEPTH words.
- Count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- Ovf_Clr  in  1  clears the Overflow flag.
- Overflow  out  1  sticky; a byte was lost because the FIFO was full.

Behaviour:
- Reset (CLR=1 at a clock edge):
  - Pointers, Count, CLR_Rec, Rd_Data, Rd_Perr, Rd_Valid, Overflow and Full go to 0; Empty goes to 1.
  - Internal Data_Ready history register goes to 0.
  - Reset applied mid-operation discards all stored words.
- Capture:
  - Internal reg dr_q <= Data_Ready every cycle.
  - A capture event is Data_Ready=1 and dr_q=0 (rising edge), sampled at edge N.
  - At edge N, {parity_err, Data_Rx} is written to mem[wr_ptr] if the FIFO is not full.
  - CLR_Rec=1 during cycle N+1 only. The ack is issued even when the byte is dropped, so the receiver never stalls.
  - Data_Ready held high for several cycles produces exactly one capture.
- Overflow:
  - A capture while Full=1 with no simultaneous accepted read drops the byte and sets Overflow.
  - Overflow clears only on CLR or Ovf_Clr=1. If Ovf_Clr and a new overflow event occur in the same cycle, set wins.
- Read:
  - Rd_En=1 with Empty=0 at edge M: Rd_Data/Rd_Perr <= mem[rd_ptr], rd_ptr advances, Rd_Valid=1 during cycle M+1. Latency is one cycle.
  - Rd_En with Empty=1 is ignored: Rd_Valid=0 and no pointer change.
  - Rd_Data/Rd_Perr hold their last value between reads.
- Simultaneous capture and read:
  - Not full, not empty: both occur; Count unchanged.
  - Full: the read is accepted and frees a slot, the write is accepted, Count stays DEPTH, Overflow is not set.
  - Empty: the write occurs and the read is ignored (no fall-through); Count becomes 1.
- Pointers and flags:
  - Pointers are ADDR_W bits and wrap modulo DEPTH.
  - Count is ADDR_W+1 bits.
  - Full = (Count==DEPTH), Empty = (Count==0); both registered and consistent with Count every cycle.

Optional Feature:
- Macro: UART_RX_PERR_DROP_EN.
- Defined:
  - Bytes captured with parity_err=1 are not written; CLR_Rec is still pulsed.
  - An extra output Perr_Cnt [7:0] counts dropped bytes, saturates at 255 and resets to 0 on CLR.
  - Rd_Perr is tied to 0.
- Undefined:
  - All bytes are stored with their parity flag as above.
  - Perr_Cnt port does not exist.

Test Plan:
- Reset then idle: CLR=1 for 2 cycles, then 0 -> Empty=1, Count=0, CLR_Rec=0, Overflow=0, Rd_Valid=0.
- Single byte: Data_Rx=8'hA5, parity_err=0, Data_Ready held high 5 cycles -> one CLR_Rec pulse one cycle after the rise, Count=1; then Rd_En one cycle -> next cycle Rd_Valid=1, Rd_Data=8'hA5, Rd_Perr=0, Empty=1.
- Fill and overflow: 17 captures of 8'h01..8'h11 with no reads -> Full=1 after the 16th, 17th dropped, Overflow=1, 17 CLR_Rec pulses; 16 reads return 8'h01..8'h10 in order; Ovf_Clr -> Overflow=0.
- Wrap-around: interleave 40 writes (8'h00..8'h27) and reads, keeping Count at 3..5 -> all 40 bytes read in order, pointers wrap twice, no Overflow.
- Simultaneous events:
  - At Full, capture of 8'h55 plus Rd_En in the same cycle -> Count stays 16, Overflow=0, 8'h55 read last.
  - At Empty, capture plus Rd_En -> Count=1, Rd_Valid=0.
- Parity and reset mid-stream:
  - Capture 8'h3C with parity_err=1 -> Rd_Perr=1 on read (macro undefined) or Perr_Cnt=1 and Count=0 (macro defined).
  - With Count=7, assert CLR -> Count=0, Empty=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer between a USART receiver and a slower consumer.
// It captures each byte on the rising edge of Data_Ready, acknowledges the receiver
// with a one-cycle CLR_Rec pulse, and queues {parity_err, Data_Rx} in a
// 2**ADDR_W-entry FIFO that the consumer pops with Rd_En.
//
// Ports:
//   CLK, CLR          clock; synchronous active-high reset
//   Data_Rx, Data_Ready, parity_err   receiver byte, level flag and parity flag
//   CLR_Rec           one-cycle acknowledge back to the receiver
//   Rd_En             pop request; Rd_Data/Rd_Perr/Rd_Valid follow one cycle later
//   Empty, Full, Count  occupancy status
//   Ovf_Clr, Overflow   sticky overflow flag and its clear
//   Perr_Cnt          count of bytes dropped for bad parity (option only)
//
// Option macro UART_RX_PERR_DROP_EN: bytes with parity_err=1 are discarded
// (still acknowledged), counted in Perr_Cnt (saturating at 255), and Rd_Perr is 0.
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [DATA_W-1:0] Data_Rx,
  input  logic              Data_Ready,
  input  logic              parity_err,
  output logic              CLR_Rec,
  input  logic              Rd_En,
  output logic [DATA_W-1:0] Rd_Data,
  output logic              Rd_Perr,
  output logic              Rd_Valid,
  output logic              Empty,
  output logic              Full,
  output logic [ADDR_W:0]   Count,
  input  logic              Ovf_Clr,
  output logic              Overflow
`ifdef UART_RX_PERR_DROP_EN
  ,
  output logic [7:0]        Perr_Cnt
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;
`ifdef UART_RX_PERR_DROP_EN
  localparam int unsigned MW    = DATA_W;
`else
  localparam int unsigned MW    = DATA_W + 1;
`endif

  logic [MW-1:0]     mem_q [DEPTH];

  logic              dr_q, dr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              clr_rec_q, clr_rec_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              ovf_q, ovf_d;
`ifdef UART_RX_PERR_DROP_EN
  logic [7:0]        perr_cnt_q, perr_cnt_d;
`else
  logic              rd_perr_q, rd_perr_d;
`endif

  logic              cap_c, store_c, rd_acc_c, wr_acc_c, ovf_set_c;
  logic [MW-1:0]     wr_word_c, rd_word_c;

  // Next-state logic for capture, pointers, occupancy and read port.
  always_comb begin
    dr_d       = Data_Ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
`ifdef UART_RX_PERR_DROP_EN
    perr_cnt_d = perr_cnt_q;
`else
    rd_perr_d  = rd_perr_q;
`endif

    // Only the rising edge of the level flag is a new byte.
    cap_c     = Data_Ready & ~dr_q;
`ifdef UART_RX_PERR_DROP_EN
    store_c   = cap_c & ~parity_err;
    wr_word_c = Data_Rx;
`else
    store_c   = cap_c;
    wr_word_c = {parity_err, Data_Rx};
`endif
    rd_acc_c  = Rd_En & ~empty_q;
    // A same-cycle pop frees a slot, so a write at Full is still accepted.
    wr_acc_c  = store_c & (~full_q | rd_acc_c);
    ovf_set_c = store_c & full_q & ~rd_acc_c;
    rd_word_c = mem_q[rd_ptr_q];

    clr_rec_d  = cap_c;
    rd_valid_d = rd_acc_c;

    if (rd_acc_c) begin
      rd_data_d = rd_word_c[DATA_W-1:0];
`ifndef UART_RX_PERR_DROP_EN
      rd_perr_d = rd_word_c[DATA_W];
`endif
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
    end
    if (wr_acc_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end

    count_d = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);

    // Set takes priority over clear.
    ovf_d = ovf_set_c | (ovf_q & ~Ovf_Clr);

`ifdef UART_RX_PERR_DROP_EN
    if (cap_c && parity_err && (perr_cnt_q != 8'hFF)) begin
      perr_cnt_d = perr_cnt_q + 8'd1;
    end
`endif
  end

  // State registers.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      dr_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      clr_rec_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
`ifdef UART_RX_PERR_DROP_EN
      perr_cnt_q <= '0;
`else
      rd_perr_q  <= 1'b0;
`endif
    end else begin
      dr_q       <= dr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      clr_rec_q  <= clr_rec_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
`ifdef UART_RX_PERR_DROP_EN
      perr_cnt_q <= perr_cnt_d;
`else
      rd_perr_q  <= rd_perr_d;
`endif
    end
  end

  // Storage array; contents are not reset, pointers define validity.
  always_ff @(posedge CLK) begin
    if (!CLR && wr_acc_c) begin
      mem_q[wr_ptr_q] <= wr_word_c;
    end
  end

  assign CLR_Rec  = clr_rec_q;
  assign Rd_Data  = rd_data_q;
  assign Rd_Valid = rd_valid_q;
  assign Empty    = empty_q;
  assign Full     = full_q;
  assign Count    = count_q;
  assign Overflow = ovf_q;
`ifdef UART_RX_PERR_DROP_EN
  assign Rd_Perr  = 1'b0;
  assign Perr_Cnt = perr_cnt_q;
`else
  assign Rd_Perr  = rd_perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: a directed vector table for reset and a single
// byte, hand-written sequences for fill/overflow, wrap, simultaneous events,
// parity and mid-stream reset, and a randomized run, all scored every cycle
// against a queue-based reference model.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [7:0] Data_Rx;
  logic       Data_Ready;
  logic       parity_err;
  logic       CLR_Rec;
  logic       Rd_En;
  logic [7:0] Rd_Data;
  logic       Rd_Perr;
  logic       Rd_Valid;
  logic       Empty;
  logic       Full;
  logic [4:0] Count;
  logic       Ovf_Clr;
  logic       Overflow;
`ifdef UART_RX_PERR_DROP_EN
  logic [7:0] Perr_Cnt;
`endif

  uart_rx_fifo dut (
    .CLK(CLK), .CLR(CLR), .Data_Rx(Data_Rx), .Data_Ready(Data_Ready),
    .parity_err(parity_err), .CLR_Rec(CLR_Rec), .Rd_En(Rd_En),
    .Rd_Data(Rd_Data), .Rd_Perr(Rd_Perr), .Rd_Valid(Rd_Valid),
    .Empty(Empty), .Full(Full), .Count(Count), .Ovf_Clr(Ovf_Clr),
    .Overflow(Overflow)
`ifdef UART_RX_PERR_DROP_EN
    , .Perr_Cnt(Perr_Cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Reference model state: queue of stored {perr, data} words plus output images.
  logic [8:0] mq[$];
  bit         m_dr, m_ovf, m_rv, m_crec, m_rp;
  logic [7:0] m_rd;
  int         m_pc;

  int checks = 0;
  int errors = 0;
  int crec_seen = 0;

  typedef struct {
    logic       clr, dr;
    logic [7:0] d;
    logic       perr, rd, oc;
    int         e_cnt;
    logic       e_crec, e_rv;
    logic [7:0] e_rd;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit cap, rd, ovs;
    cap = Data_Ready && !m_dr;
    if (CLR) begin
      mq.delete();
      m_dr = 0; m_ovf = 0; m_rv = 0; m_crec = 0; m_rd = 8'h00; m_rp = 0; m_pc = 0;
    end else begin
      m_dr   = Data_Ready;
      m_crec = cap;
      rd     = Rd_En && (mq.size() > 0);
      m_rv   = rd;
      ovs    = 0;
      if (rd) {m_rp, m_rd} = mq.pop_front();
      if (cap) begin
`ifdef UART_RX_PERR_DROP_EN
        if (parity_err) begin
          if (m_pc < 255) m_pc++;
        end else
`endif
        if (mq.size() < 16) mq.push_back({parity_err, Data_Rx});
        else ovs = 1;
      end
      m_ovf = ovs || (m_ovf && !Ovf_Clr);
    end
  endtask

  task automatic step(input logic clr, input logic dr, input logic [7:0] d,
                      input logic perr, input logic rd, input logic oc);
    CLR = clr; Data_Ready = dr; Data_Rx = d; parity_err = perr; Rd_En = rd; Ovf_Clr = oc;
    model_edge();
    @(posedge CLK); #1;
    if (CLR_Rec === 1'b1) crec_seen++;
    chk("count",    32'(Count),    32'(mq.size()));
    chk("empty",    32'(Empty),    32'(mq.size() == 0));
    chk("full",     32'(Full),     32'(mq.size() == 16));
    chk("clr_rec",  32'(CLR_Rec),  32'(m_crec));
    chk("rd_valid", 32'(Rd_Valid), 32'(m_rv));
    chk("rd_data",  32'(Rd_Data),  32'(m_rd));
    chk("rd_perr",  32'(Rd_Perr),  32'(m_rp));
    chk("overflow", 32'(Overflow), 32'(m_ovf));
`ifdef UART_RX_PERR_DROP_EN
    chk("perr_cnt", 32'(Perr_Cnt), 32'(m_pc));
`endif
  endtask

  // One receiver frame: Data_Ready high one cycle then low.
  task automatic capture(input logic [7:0] d, input logic perr, input logic rd);
    step(1'b0, 1'b1, d, perr, rd, 1'b0);
    step(1'b0, 1'b0, d, perr, 1'b0, 1'b0);
  endtask

  initial begin
    int rdn;
    CLR = 1'b1; Data_Ready = 1'b0; Data_Rx = 8'h00; parity_err = 1'b0;
    Rd_En = 1'b0; Ovf_Clr = 1'b0;

    // clr dr d perr rd oc | cnt crec rv rd_data
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00};
    vecs[1]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00};
    vecs[3]  = '{0, 1, 8'hA5, 0, 0, 0, 1, 1, 0, 8'h00};
    vecs[4]  = '{0, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[5]  = '{0, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[6]  = '{0, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[7]  = '{0, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[8]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00};
    vecs[9]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 1, 8'hA5};
    vecs[10] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hA5};
    vecs[11] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'hA5};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].clr, vecs[i].dr, vecs[i].d, vecs[i].perr, vecs[i].rd, vecs[i].oc);
      chk("vec_count",    32'(Count),    32'(vecs[i].e_cnt));
      chk("vec_clr_rec",  32'(CLR_Rec),  32'(vecs[i].e_crec));
      chk("vec_rd_valid", 32'(Rd_Valid), 32'(vecs[i].e_rv));
      chk("vec_rd_data",  32'(Rd_Data),  32'(vecs[i].e_rd));
    end

    // Fill to Full, overflow on the 17th, drain in order, clear Overflow.
    crec_seen = 0;
    for (int i = 1; i <= 17; i++) begin
      capture(8'(i), 1'b0, 1'b0);
      if (i == 16) chk("fill_full16", 32'(Full), 32'd1);
    end
    chk("fill_overflow", 32'(Overflow), 32'd1);
    chk("fill_ack_pulses", 32'(crec_seen), 32'd17);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("fill_rd_order", 32'(Rd_Data), 32'(i));
    end
    chk("fill_drained", 32'(Empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clear", 32'(Overflow), 32'd0);

    // Wrap-around: keep four words in flight across 40 writes.
    rdn = 0;
    for (int i = 0; i < 4; i++) capture(8'(i), 1'b0, 1'b0);
    for (int i = 4; i < 40; i++) begin
      capture(8'(i), 1'b0, 1'b1);
      chk("wrap_rd_order", 32'(Rd_Data), 32'(rdn));
      rdn++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("wrap_tail_order", 32'(Rd_Data), 32'(rdn));
      rdn++;
    end
    chk("wrap_no_ovf", 32'(Overflow), 32'd0);

    // Capture and pop together while Full.
    for (int i = 0; i < 16; i++) capture(8'h80 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    chk("full_simul_count", 32'(Count), 32'd16);
    chk("full_simul_ovf", 32'(Overflow), 32'd0);
    chk("full_simul_rd", 32'(Rd_Data), 32'h80);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("full_simul_last", 32'(Rd_Data), 32'h55);

    // Capture and pop together while Empty: no fall-through.
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    chk("empty_simul_count", 32'(Count), 32'd1);
    chk("empty_simul_rv", 32'(Rd_Valid), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("empty_simul_rd", 32'(Rd_Data), 32'h66);

    // Parity-flagged byte.
    capture(8'h3C, 1'b1, 1'b0);
`ifdef UART_RX_PERR_DROP_EN
    chk("perr_drop_cnt", 32'(Perr_Cnt), 32'd1);
    chk("perr_drop_count", 32'(Count), 32'd0);
`else
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("perr_flag", 32'(Rd_Perr), 32'd1);
    chk("perr_data", 32'(Rd_Data), 32'h3C);
`endif

    // Reset with seven words stored.
    for (int i = 0; i < 7; i++) capture(8'hC0 + 8'(i), 1'b0, 1'b0);
    chk("midrst_pre", 32'(Count), 32'd7);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("midrst_count", 32'(Count), 32'd0);
    chk("midrst_empty", 32'(Empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Randomized traffic alternating read-heavy and write-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      int rdp;
      rdp = ((n / 500) % 2 == 1) ? 15 : 70;
      step(1'($urandom_range(0, 399) == 0),
           1'($urandom_range(0, 1)),
           8'($urandom),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 99) < rdp),
           1'($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
